id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage RV32I core; sits directly upstream of the ALU and produces its dataA, dataB, func and aluOp inputs.
- Registers decoded operands and controls from ID, then resolves EX-stage operand forwarding from MEM and WB.
- Detects load-use hazards and inserts a bubble.
- Honours pipeline stall and flush from the hazard/branch logic.

---
 rtl/core_pkg.sv | 27 ++
 rtl/id_ex_stage_fwd_mux.sv | 32 +++
 rtl/id_ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: ALU op classes, funct3 codes, register address width, control bundle.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_FUNCT = 3'b010;
  localparam int         ALU_OP_ITYPE_BIT = 2;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand EX forwarding selector: MEM result beats WB result beats register-file value.
// Purely combinational; x0 is never forwarded.
module fwd_mux
  import core_pkg::*;
#(
  parameter int width    = 32,
  parameter int regAddrW = REG_ADDR_W
) (
  input  logic [regAddrW-1:0] rs_addr,
  input  logic [width-1:0]    rf_data,
  input  logic [regAddrW-1:0] mem_rd_addr,
  input  logic                mem_reg_write,
  input  logic [width-1:0]    mem_result,
  input  logic [regAddrW-1:0] wb_rd_addr,
  input  logic                wb_reg_write,
  input  logic [width-1:0]    wb_result,
  output logic [width-1:0]    data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
  assign wb_hit  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == rs_addr);

  always_comb begin
    data = rf_data;
    if (mem_hit)     data = mem_result;
    else if (wb_hit) data = wb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX-stage operand forwarding.
// Update priority per edge: flush > stall > load-use bubble > load.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int width    = 32,
  parameter int regAddrW = REG_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [width-1:0]    id_pc,
  input  logic [width-1:0]    id_rs1_data,
  input  logic [width-1:0]    id_rs2_data,
  input  logic [width-1:0]    id_imm,
  input  logic [regAddrW-1:0] id_rs1_addr,
  input  logic [regAddrW-1:0] id_rs2_addr,
  input  logic [regAddrW-1:0] id_rd_addr,
  input  logic [3:0]          id_func,
  input  logic [2:0]          id_alu_op,
  input  logic                id_src_a_pc,
  input  logic                id_src_b_imm,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_branch,
  input  logic [regAddrW-1:0] mem_rd_addr,
  input  logic                mem_reg_write,
  input  logic [width-1:0]    mem_result,
  input  logic [regAddrW-1:0] wb_rd_addr,
  input  logic                wb_reg_write,
  input  logic [width-1:0]    wb_result,
  output logic                load_use_stall,
  output logic                ex_valid,
  output logic [width-1:0]    alu_dataA,
  output logic [width-1:0]    alu_dataB,
  output logic [3:0]          alu_func,
  output logic [2:0]          alu_aluOp,
  output logic [width-1:0]    ex_store_data,
  output logic [width-1:0]    ex_pc,
  output logic [regAddrW-1:0] ex_rd_addr,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_branch
);

  logic                valid_q,     valid_d;
  ctrl_t               ctrl_q,      ctrl_d;
  logic [width-1:0]    pc_q,        pc_d;
  logic [width-1:0]    rs1_data_q,  rs1_data_d;
  logic [width-1:0]    rs2_data_q,  rs2_data_d;
  logic [width-1:0]    imm_q,       imm_d;
  logic [regAddrW-1:0] rs1_addr_q,  rs1_addr_d;
  logic [regAddrW-1:0] rs2_addr_q,  rs2_addr_d;
  logic [regAddrW-1:0] rd_addr_q,   rd_addr_d;
  logic [3:0]          func_q,      func_d;
  logic [2:0]          alu_op_q,    alu_op_d;
  logic                src_a_pc_q,  src_a_pc_d;
  logic                src_b_imm_q, src_b_imm_d;

  logic                load_use_hazard;
  ctrl_t               id_ctrl;
  logic [width-1:0]    fwd_rs1;
  logic [width-1:0]    fwd_rs2;

  assign id_ctrl = '{reg_write: id_reg_write, mem_read: id_mem_read,
                     mem_write: id_mem_write, branch: id_branch};

  // Conservative: rs2 match stalls even for instructions that ignore rs2.
  assign load_use_hazard = valid_q && ctrl_q.mem_read && (rd_addr_q != '0) && id_valid &&
                           ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));
  assign load_use_stall  = load_use_hazard && !flush;

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    func_d      = func_q;
    alu_op_d    = alu_op_q;
    src_a_pc_d  = src_a_pc_q;
    src_b_imm_d = src_b_imm_q;
    if (flush) begin
      valid_d     = 1'b0;
      ctrl_d      = '0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_addr_d  = '0;
      rs2_addr_d  = '0;
      rd_addr_d   = '0;
      func_d      = '0;
      alu_op_d    = ALU_OP_ADD;
      src_a_pc_d  = 1'b0;
      src_b_imm_d = 1'b0;
    end else if (!stall) begin
      // A bubble still loads data fields; only validity and side-effect controls are dropped.
      valid_d     = id_valid && !load_use_hazard;
      ctrl_d      = valid_d ? id_ctrl : '0;
      pc_d        = id_pc;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      func_d      = id_func;
      alu_op_d    = id_alu_op;
      src_a_pc_d  = id_src_a_pc;
      src_b_imm_d = id_src_b_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      func_q      <= '0;
      alu_op_q    <= ALU_OP_ADD;
      src_a_pc_q  <= 1'b0;
      src_b_imm_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      func_q      <= func_d;
      alu_op_q    <= alu_op_d;
      src_a_pc_q  <= src_a_pc_d;
      src_b_imm_q <= src_b_imm_d;
    end
  end

  fwd_mux #(.width(width), .regAddrW(regAddrW)) u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .rf_data       (rs1_data_q),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .data          (fwd_rs1)
  );

  fwd_mux #(.width(width), .regAddrW(regAddrW)) u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .rf_data       (rs2_data_q),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .data          (fwd_rs2)
  );

  assign alu_dataA     = src_a_pc_q  ? pc_q  : fwd_rs1;
  assign alu_dataB     = src_b_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_func      = func_q;
  assign alu_aluOp     = alu_op_q;
  assign ex_pc         = pc_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-instruction EX model checked every cycle plus literal spot checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 0, flush = 0, id_valid = 0;
  logic [31:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
  logic [4:0]  id_rs1_addr = 0, id_rs2_addr = 0, id_rd_addr = 0;
  logic [3:0]  id_func = 0;
  logic [2:0]  id_alu_op = 0;
  logic        id_src_a_pc = 0, id_src_b_imm = 0;
  logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_branch = 0;
  logic [4:0]  mem_rd_addr = 0, wb_rd_addr = 0;
  logic        mem_reg_write = 0, wb_reg_write = 0;
  logic [31:0] mem_result = 0, wb_result = 0;

  logic        load_use_stall, ex_valid;
  logic [31:0] alu_dataA, alu_dataB, ex_store_data, ex_pc;
  logic [3:0]  alu_func;
  logic [2:0]  alu_aluOp;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_func(id_func), .id_alu_op(id_alu_op), .id_src_a_pc(id_src_a_pc),
    .id_src_b_imm(id_src_b_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .alu_dataA(alu_dataA),
    .alu_dataB(alu_dataB), .alu_func(alu_func), .alu_aluOp(alu_aluOp),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The instruction currently sitting in EX, as an architectural record.
  typedef struct {
    logic        valid;
    logic        rw, mr, mw, br;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  a1, a2, rd;
    logic [3:0]  func;
    logic [2:0]  op;
    logic        spc, simm;
  } ex_instr_t;

  ex_instr_t m_ex = '{default: '0};

  function automatic logic model_hazard();
    return m_ex.valid && m_ex.mr && m_ex.rd != 0 && id_valid &&
           (m_ex.rd == id_rs1_addr || m_ex.rd == id_rs2_addr);
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return rf;
    if (mem_reg_write && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return rf;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex <= '{default: '0};
    end else if (flush) begin
      m_ex <= '{default: '0};
    end else if (!stall) begin
      logic bubble;
      logic live;
      bubble = model_hazard();
      live   = id_valid && !bubble;
      m_ex <= '{valid: live, rw: live && id_reg_write, mr: live && id_mem_read,
                mw: live && id_mem_write, br: live && id_branch,
                pc: id_pc, r1: id_rs1_data, r2: id_rs2_data, imm: id_imm,
                a1: id_rs1_addr, a2: id_rs2_addr, rd: id_rd_addr,
                func: id_func, op: id_alu_op, spc: id_src_a_pc, simm: id_src_b_imm};
    end
  end

  always @(negedge clk) begin
    logic [31:0] op1, op2;
    op1 = model_operand(m_ex.a1, m_ex.r1);
    op2 = model_operand(m_ex.a2, m_ex.r2);
    chk("load_use_stall", {31'b0, load_use_stall}, {31'b0, model_hazard() && !flush});
    chk("ex_valid",       {31'b0, ex_valid},       {31'b0, m_ex.valid});
    chk("alu_dataA",      alu_dataA,     m_ex.spc  ? m_ex.pc  : op1);
    chk("alu_dataB",      alu_dataB,     m_ex.simm ? m_ex.imm : op2);
    chk("ex_store_data",  ex_store_data, op2);
    chk("alu_func",       {28'b0, alu_func},  {28'b0, m_ex.func});
    chk("alu_aluOp",      {29'b0, alu_aluOp}, {29'b0, m_ex.op});
    chk("ex_pc",          ex_pc, m_ex.pc);
    chk("ex_rd_addr",     {27'b0, ex_rd_addr}, {27'b0, m_ex.rd});
    chk("ex_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
                   {28'b0, m_ex.rw, m_ex.mr, m_ex.mw, m_ex.br});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_func = 0; id_alu_op = 0;
    id_src_a_pc = 0; id_src_b_imm = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
  endtask

  task automatic fwd_clear();
    mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    #10 rst_n = 1;
    #1 chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_dataA", alu_dataA, 32'd0);
    chk("rst_aluOp", {29'b0, alu_aluOp}, 32'd0);
    cyc();
    chk("post_rst_valid", {31'b0, ex_valid}, 32'd0);

    // ADD x3, x1, x2
    id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 3;
    id_rs1_data = 5; id_rs2_data = 7; id_alu_op = 3'b010; id_func = 0; id_reg_write = 1;
    cyc();
    chk("add_dataA", alu_dataA, 32'd5);
    chk("add_dataB", alu_dataB, 32'd7);
    chk("add_func", {28'b0, alu_func}, 32'd0);
    chk("add_rd", {27'b0, ex_rd_addr}, 32'd3);
    chk("add_rw", {31'b0, ex_reg_write}, 32'd1);

    // Forwarding on rs1=x4, rs2=x4
    id_clear();
    id_valid = 1; id_rs1_addr = 4; id_rs2_addr = 4; id_rd_addr = 9;
    id_rs1_data = 32'h44; id_rs2_data = 32'h45; id_alu_op = 3'b010; id_reg_write = 1;
    cyc();
    id_clear();
    mem_rd_addr = 4; mem_reg_write = 1; mem_result = 32'h10;
    wb_rd_addr = 4; wb_reg_write = 1; wb_result = 32'h20;
    #1 chk("fwd_mem_wins", alu_dataA, 32'h10);
    chk("fwd_store_mem", ex_store_data, 32'h10);
    mem_rd_addr = 0;
    #1 chk("fwd_wb", alu_dataA, 32'h20);
    wb_rd_addr = 0;
    #1 chk("fwd_rf", alu_dataA, 32'h44);
    chk("fwd_rf_b", alu_dataB, 32'h45);
    mem_rd_addr = 4; mem_reg_write = 0;
    #1 chk("fwd_mem_nowrite", alu_dataA, 32'h44);

    // x0 is never forwarded
    id_valid = 1; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 32'h99; id_rs2_data = 32'h98;
    cyc();
    id_clear();
    mem_rd_addr = 0; mem_reg_write = 1; mem_result = 32'h10;
    wb_rd_addr = 0; wb_reg_write = 1; wb_result = 32'h20;
    #1 chk("x0_dataA", alu_dataA, 32'h99);
    chk("x0_store", ex_store_data, 32'h98);
    fwd_clear();

    // LW x5 then a consumer reading x5 as rs2
    id_valid = 1; id_rs1_addr = 1; id_rd_addr = 5; id_mem_read = 1; id_reg_write = 1;
    id_alu_op = 3'b100; id_src_b_imm = 1; id_imm = 4;
    cyc();
    id_clear();
    id_valid = 1; id_rs1_addr = 6; id_rs2_addr = 5; id_rd_addr = 8; id_reg_write = 1;
    #1 chk("lu_stall", {31'b0, load_use_stall}, 32'd1);
    cyc();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'b0, ex_reg_write}, 32'd0);
    chk("lu_released", {31'b0, load_use_stall}, 32'd0);
    cyc();
    chk("lu_consumer_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_consumer_rd", {27'b0, ex_rd_addr}, 32'd8);

    // Flush suppresses the load-use stall
    id_clear();
    id_valid = 1; id_rd_addr = 5; id_mem_read = 1; id_reg_write = 1;
    cyc();
    id_clear();
    id_valid = 1; id_rs1_addr = 5; id_rd_addr = 10; id_reg_write = 1;
    flush = 1;
    #1 chk("lu_flush_supp", {31'b0, load_use_stall}, 32'd0);
    flush = 0;
    #1 chk("lu_noflush", {31'b0, load_use_stall}, 32'd1);
    cyc();

    // LW x0 never stalls a reader of x0
    id_clear();
    id_valid = 1; id_rd_addr = 0; id_mem_read = 1; id_reg_write = 1;
    cyc();
    id_clear();
    id_valid = 1; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 2;
    #1 chk("lu_x0", {31'b0, load_use_stall}, 32'd0);

    // ADDI x6, imm=-1, held by stall for three cycles
    id_clear();
    id_valid = 1; id_rs1_addr = 1; id_rd_addr = 6; id_imm = 32'hFFFF_FFFF;
    id_src_b_imm = 1; id_alu_op = 3'b100; id_reg_write = 1;
    cyc();
    id_clear();
    id_valid = 1; id_rd_addr = 11; id_imm = 5; id_src_b_imm = 1; id_reg_write = 1;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_dataB", alu_dataB, 32'hFFFF_FFFF);
      chk("stall_rd", {27'b0, ex_rd_addr}, 32'd6);
    end
    flush = 1;
    cyc();
    chk("flush_stall_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_stall_rw", {31'b0, ex_reg_write}, 32'd0);
    flush = 0; stall = 0;

    // Invalid ID must not create side effects
    id_clear();
    id_reg_write = 1; id_mem_write = 1; id_branch = 1; id_rd_addr = 12;
    cyc();
    chk("inv_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'd0);

    // AUIPC with pc=0x100, imm=0x1000
    id_clear();
    id_valid = 1; id_pc = 32'h100; id_imm = 32'h1000; id_src_a_pc = 1; id_src_b_imm = 1;
    id_alu_op = 3'b000; id_rd_addr = 7; id_reg_write = 1; id_rs1_data = 32'hDEAD;
    cyc();
    chk("auipc_dataA", alu_dataA, 32'h100);
    chk("auipc_dataB", alu_dataB, 32'h1000);
    chk("auipc_op", {29'b0, alu_aluOp}, 32'd0);

    // Reset asserted mid-cycle with a valid store in EX
    id_clear();
    id_valid = 1; id_mem_write = 1; id_rs1_data = 32'h55; id_rd_addr = 3;
    cyc();
    #1 rst_n = 0;
    #1 chk("midrst_valid", {31'b0, ex_valid}, 32'd0);
    chk("midrst_mw", {31'b0, ex_mem_write}, 32'd0);
    chk("midrst_dataA", alu_dataA, 32'd0);
    id_clear();
    cyc();
    rst_n = 1;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete, expected completion before 50000");
    $fatal(1);
  end

endmodule
